// File: rtl/jtcps1_dwnld_bridge.sv
// jtcps1_dwnld_bridge
// -------------------
// Bridge between the ioctl ROM download stream and the SDRAM programming
// port during game load.
//   * The leading REGSIZE bytes are CPS-B configuration bytes. Each one is
//     sent out as a single-cycle cfg_we strobe and never reaches SDRAM.
//   * All later bytes are rebased by removing REGSIZE. Bytes in the GFX
//     region have address bits [2:1] swapped. The bytes are then queued in
//     a 2**FIFO_AW entry FIFO and issued as byte-masked SDRAM writes under
//     a prog_we / sdram_ack handshake.
//
// Optional build macro: JTCPS1_DWNLD_CHECKSUM_EN
//   Defined   : checksum is a 16-bit wrapping sum of the acknowledged data bytes.
//   Undefined : checksum is tied to zero.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   downloading               download in progress (ioctl_wr is ignored when low)
//   ioctl_addr/data/wr        download byte stream
//   prog_addr/data/mask/we    SDRAM write request (word address, byte, active-low lanes)
//   sdram_ack                 controller accepted the request
//   cfg_we/addr/data          CPS-B configuration byte strobe
//   busy                      FIFO not empty or a request outstanding
//   overflow                  sticky: a byte was dropped because the FIFO was full
//   checksum                  sum of written data bytes (see macro above)

module jtcps1_dwnld_bridge #(
    parameter int          REGSIZE   = 21,
    parameter logic [21:0] GFX_START = 22'h0A_8000,
    parameter logic [21:0] GFX_END   = 22'h3A_8000,
    parameter int          FIFO_AW   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        downloading,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        sdram_ack,
    output logic        cfg_we,
    output logic [4:0]  cfg_addr,
    output logic [7:0]  cfg_data,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] checksum
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic {IDLE, REQ} state_t;

    state_t              state, state_nxt;
    logic [22:0]         b, r, b_sw;
    logic                in_gfx, accept, is_cfg, push, pop, full, drop;
    logic                dl_q, dl_rise;
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    count;
    logic [30:0]         fifo_mem [DEPTH];   // {word address, byte select, data}
    logic                prog_lsb;

    // Address translation: remove the config header, then swap bits [2:1]
    // of the offset inside the GFX region.
    // NOTE: every signal written in always_comb is assigned first so no latch can be inferred.
    always_comb begin
        b      = ioctl_addr - 23'(REGSIZE);
        in_gfx = (b >= {1'b0, GFX_START}) && (b < {1'b0, GFX_END});
        r      = b - {1'b0, GFX_START};
        b_sw   = in_gfx ? {1'b0, GFX_START} + {r[22:3], r[1], r[2], r[0]} : b;
    end

    assign accept  = downloading & ioctl_wr;
    assign is_cfg  = ioctl_addr < 23'(REGSIZE);
    assign dl_rise = downloading & ~dl_q;
    assign full    = count == (FIFO_AW + 1)'(DEPTH);
    assign pop     = (state == IDLE) && (count != '0);
    // A push on a full FIFO only fits when a pop frees a slot on the same edge.
    assign push    = accept & ~is_cfg & (~full | pop);
    assign drop    = accept & ~is_cfg & full & ~pop;
    assign busy    = (count != '0) | prog_we;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dl_q     <= 1'b0;
            cfg_we   <= 1'b0;
            cfg_addr <= '0;
            cfg_data <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_lsb  <= 1'b0;
        end else begin
            dl_q     <= downloading;
            cfg_we   <= accept & is_cfg;
            if (accept & is_cfg) begin
                cfg_addr <= ioctl_addr[4:0];
                cfg_data <= ioctl_data;
            end
            overflow <= (overflow & ~dl_rise) | drop;
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
                {prog_addr, prog_lsb, prog_data} <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {b_sw, ioctl_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Request FSM. prog_we and prog_mask are decoded from the state, so an
    // asynchronous reset drops the request immediately.
    always_comb begin
        state_nxt = state;
        prog_we   = 1'b0;
        prog_mask = 2'b11;
        case (state)
            IDLE: if (count != '0) state_nxt = REQ;
            REQ: begin
                prog_we   = 1'b1;
                prog_mask = prog_lsb ? 2'b01 : 2'b10;
                if (sdram_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef JTCPS1_DWNLD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                             checksum <= '0;
        else if (dl_rise)                      checksum <= '0;
        else if ((state == REQ) && sdram_ack)  checksum <= checksum + {8'd0, prog_data};
    end
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_jtcps1_dwnld_bridge.sv
// Testbench for jtcps1_dwnld_bridge: config strobes, address translation
// vectors, overflow, drain after download end, reset mid-request, checksum.

module tb_jtcps1_dwnld_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        downloading;
    logic [22:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        sdram_ack;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        busy;
    logic        overflow;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    jtcps1_dwnld_bridge dut (
        .clk(clk), .rstn(rstn), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .sdram_ack(sdram_ack),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy), .overflow(overflow), .checksum(checksum)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [22:0] addr;
        logic [7:0]  data;
        logic [21:0] exp_addr;
        logic [1:0]  exp_mask;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte for exactly one rising edge; returns 1 time unit after it.
    task automatic send(input logic [22:0] a, input logic [7:0] d);
        tick();
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_we(input string name);
        int n = 0;
        while (!prog_we && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, " request timeout"}, prog_we, 1);
    endtask

    // Waits for a request, checks it, holds it 'hold' cycles, then acknowledges it.
    task automatic serve(input string name, input logic [21:0] ea, input logic [7:0] ed,
                         input logic [1:0] em, input int hold);
        wait_we(name);
        check({name, " prog_addr"}, prog_addr, ea);
        check({name, " prog_data"}, prog_data, ed);
        check({name, " prog_mask"}, prog_mask, em);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({name, " held prog_we"}, prog_we, 1);
            check({name, " held prog_addr"}, prog_addr, ea);
            check({name, " held prog_data"}, prog_data, ed);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        @(negedge clk);
        check({name, " prog_we after ack"}, prog_we, 0);
        check({name, " prog_mask after ack"}, prog_mask, 2'b11);
    endtask

    // Confirms no request appears over a few cycles and the bridge is idle.
    task automatic expect_quiet(input string name);
        int seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (prog_we) seen++;
        end
        check({name, " extra requests"}, seen, 0);
        check({name, " busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{23'd24,            8'hA5, 22'h00_0001, 2'b01};
        vecs[1] = '{23'h0A_8017,       8'h11, 22'h05_4002, 2'b10};  // b = GFX_START+2
        vecs[2] = '{23'h3A_8015,       8'h22, 22'h1D_4000, 2'b10};  // b = GFX_END
        vecs[3] = '{23'h0A_8015,       8'h33, 22'h05_4000, 2'b10};  // b = GFX_START
        vecs[4] = '{23'h0A_801A,       8'h44, 22'h05_4001, 2'b01};  // r=5 -> 3
        vecs[5] = '{23'h3A_8014,       8'h55, 22'h1D_3FFF, 2'b01};  // b = GFX_END-1
        vecs[6] = '{23'h0A_8014,       8'h66, 22'h05_3FFF, 2'b01};  // b = GFX_START-1
        vecs[7] = '{23'h0A_801F,       8'h77, 22'h05_4006, 2'b10};  // r=A -> C

        rstn = 1'b0; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        ioctl_wr = 1'b0; sdram_ack = 1'b0;

        #3;
        check("reset prog_we",   prog_we,   0);
        check("reset prog_mask", prog_mask, 2'b11);
        check("reset prog_addr", prog_addr, 0);
        check("reset cfg_we",    cfg_we,    0);
        check("reset busy",      busy,      0);
        check("reset overflow",  overflow,  0);
        check("reset checksum",  checksum,  0);
        #9 rstn = 1'b1;

        // Bytes ignored while not downloading.
        send(23'd30, 8'h99);
        @(negedge clk);
        check("idle-download busy", busy, 0);
        check("idle-download cfg_we", cfg_we, 0);

        tick();
        downloading = 1'b1;

        // Config header.
        for (int i = 0; i < 21; i++) begin
            send(23'(i), 8'(8'h40 + i));
            @(negedge clk);
            check($sformatf("cfg%0d cfg_we", i),   cfg_we,   1);
            check($sformatf("cfg%0d cfg_addr", i), cfg_addr, i);
            check($sformatf("cfg%0d cfg_data", i), cfg_data, 8'h40 + i);
            check($sformatf("cfg%0d prog_we", i),  prog_we,  0);
            check($sformatf("cfg%0d busy", i),     busy,     0);
            @(negedge clk);
            check($sformatf("cfg%0d cfg_we low", i), cfg_we, 0);
        end

        // Ack while idle is ignored.
        sdram_ack = 1'b1;
        repeat (3) tick();
        sdram_ack = 1'b0;
        @(negedge clk);
        check("idle ack prog_we", prog_we, 0);
        check("idle ack busy",    busy,    0);

        // Address translation vectors with latency checks.
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].addr, vecs[v].data);
            @(negedge clk);
            check($sformatf("vec%0d cfg_we", v),       cfg_we,  0);
            check($sformatf("vec%0d prog_we +1", v),   prog_we, 0);
            check($sformatf("vec%0d busy +1", v),      busy,    1);
            @(negedge clk);
            check($sformatf("vec%0d prog_we +2", v),   prog_we, 1);
            serve($sformatf("vec%0d", v), vecs[v].exp_addr, vecs[v].data,
                  vecs[v].exp_mask, (v == 0) ? 5 : 1);
            check($sformatf("vec%0d busy after", v), busy, 0);
        end

        // Overflow: six consecutive strobes with no acks.
        tick();
        for (int k = 0; k < 6; k++) begin
            ioctl_addr = 23'(21 + 2 * k);
            ioctl_data = 8'(8'h10 + k);
            ioctl_wr   = 1'b1;
            tick();
        end
        ioctl_wr = 1'b0;
        @(negedge clk);
        check("ovf overflow", overflow, 1);
        check("ovf busy",     busy,     1);
        for (int k = 0; k < 5; k++)
            serve($sformatf("ovf%0d", k), 22'(k), 8'(8'h10 + k), 2'b10, 0);
        expect_quiet("ovf drain");
        check("ovf sticky", overflow, 1);
        tick();
        downloading = 1'b0;
        tick();
        downloading = 1'b1;
        tick();
        @(negedge clk);
        check("ovf cleared by restart", overflow, 0);

        // Drain after download ends; later bytes are refused.
        for (int k = 0; k < 3; k++) send(23'(21 + 100 + k), 8'(8'hC0 + k));
        tick();
        downloading = 1'b0;
        send(23'(21 + 200), 8'hEE);
        @(negedge clk);
        check("drain busy", busy, 1);
        serve("drain0", 22'd50, 8'hC0, 2'b10, 0);
        serve("drain1", 22'd50, 8'hC1, 2'b01, 0);
        serve("drain2", 22'd51, 8'hC2, 2'b10, 0);
        expect_quiet("drain");
        tick();
        downloading = 1'b1;

        // Reset during a request with a second byte queued.
        send(23'd27, 8'h77);
        send(23'd29, 8'h78);
        wait_we("rst");
        #2 rstn = 1'b0;
        #1;
        check("rst prog_we async",   prog_we,   0);
        check("rst busy async",      busy,      0);
        check("rst prog_mask async", prog_mask, 2'b11);
        @(negedge clk);
        #2 rstn = 1'b1;
        expect_quiet("rst lost data");

        // Checksum over three data bytes.
        send(23'd31, 8'hFF);
        serve("cks0", 22'd5, 8'hFF, 2'b10, 0);
        send(23'd32, 8'h02);
        serve("cks1", 22'd5, 8'h02, 2'b01, 0);
        send(23'd33, 8'h10);
        serve("cks2", 22'd6, 8'h10, 2'b10, 0);
`ifdef JTCPS1_DWNLD_CHECKSUM_EN
        check("checksum sum", checksum, 16'h0111);
`else
        check("checksum tied low", checksum, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
